// File: rtl/uart_fifo_pkg.sv
// Shared constants and helpers for the parametrised UART FIFO and the UART
// status-register decode that reports its fill level.
package uart_fifo_pkg;

    localparam int UART_FIFO_WIDTH      = 32'sd8;
    localparam int UART_FIFO_DEPTH_LOG2 = 32'sd9;

    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 32'sd1;
            end
        end
        return result;
    endfunction

    // One extra bit so the count can represent a completely full FIFO.
    function automatic int level_width(input int depth_log2);
        return depth_log2 + 32'sd1;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port with enable.
// The array has no reset so it maps onto block RAM; only the read register resets.
module uart_fifo_ram #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem_r [0:(1 << DEPTH_LOG2)-1];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port (read-before-write on an address collision).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= {WIDTH{1'b0}};
        end else if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/uart_fifo_gen.sv
// Parametrised synchronous UART FIFO with level, almost-full, sticky overflow and flush.
// Define UART_FIFO_FWFT_EN for first-word fall-through output; default is standard mode.
module uart_fifo_gen
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH      = UART_FIFO_WIDTH,
    parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2,
    parameter int AF_LEVEL   = (32'sd1 << DEPTH_LOG2) - 32'sd16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [WIDTH-1:0]                      wrdata,
    input  logic                                  wr_en,
    output logic [WIDTH-1:0]                      rddata,
    input  logic                                  rd_en,
    output logic                                  empty,
    output logic                                  full,
    output logic [level_width(DEPTH_LOG2)-1:0]    level,
    output logic                                  almost_full,
    output logic                                  overflow,
    input  logic                                  ovf_clr
);

    localparam int             PW   = level_width(DEPTH_LOG2);
    localparam logic [PW-1:0]  AF_V = PW'(AF_LEVEL);

    logic [PW-1:0]    wridx_r;
    logic [PW-1:0]    rdidx_r;
    logic [PW-1:0]    hdidx_s;
    logic [PW-1:0]    level_s;
    logic             overflow_r;
    logic             empty_mem_s;
    logic             full_s;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic             ram_re_s;
    logic [WIDTH-1:0] ram_q_s;

    assign empty_mem_s = (wridx_r == rdidx_r);
    assign full_s      = (wridx_r[DEPTH_LOG2-1:0] == hdidx_s[DEPTH_LOG2-1:0]) &&
                         (wridx_r[DEPTH_LOG2] != hdidx_s[DEPTH_LOG2]);
    assign level_s     = wridx_r - hdidx_s;
    assign wr_acc_s    = wr_en && !full_s;

`ifdef UART_FIFO_FWFT_EN
    // popidx counts words handed to the consumer, so level includes staged words.
    logic [PW-1:0]    popidx_r;
    logic             ram_valid_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_q_r;
    logic             pop_s;
    logic             out_free_s;
    logic             fetch_s;

    assign pop_s      = rd_en && out_valid_r;
    assign out_free_s = !out_valid_r || pop_s;
    assign fetch_s    = !empty_mem_s && (!ram_valid_r || out_free_s);
    assign hdidx_s    = popidx_r;
    assign rd_acc_s   = fetch_s;
    assign ram_re_s   = fetch_s;
    assign empty      = !out_valid_r;
    assign rddata     = out_q_r;

    // Two-stage prefetch: RAM read register, then the visible output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            popidx_r    <= {PW{1'b0}};
            ram_valid_r <= 1'b0;
            out_valid_r <= 1'b0;
            out_q_r     <= {WIDTH{1'b0}};
        end else if (flush) begin
            popidx_r    <= {PW{1'b0}};
            ram_valid_r <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (pop_s) begin
                popidx_r <= popidx_r + PW'(1);
            end
            ram_valid_r <= fetch_s || (ram_valid_r && !out_free_s);
            if (ram_valid_r && out_free_s) begin
                out_q_r     <= ram_q_s;
                out_valid_r <= 1'b1;
            end else if (pop_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end
`else
    assign hdidx_s  = rdidx_r;
    assign rd_acc_s = rd_en && !empty_mem_s;
    assign ram_re_s = 1'b1;
    assign empty    = empty_mem_s;
    assign rddata   = ram_q_s;
`endif

    // Pointer and overflow state; flush outranks every other request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wridx_r    <= {PW{1'b0}};
            rdidx_r    <= {PW{1'b0}};
            overflow_r <= 1'b0;
        end else if (flush) begin
            wridx_r    <= {PW{1'b0}};
            rdidx_r    <= {PW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wridx_r <= wridx_r + PW'(1);
            end
            if (rd_acc_s) begin
                rdidx_r <= rdidx_r + PW'(1);
            end
            if (wr_en && full_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign full        = full_s;
    assign level       = level_s;
    assign almost_full = (level_s >= AF_V);
    assign overflow    = overflow_r;

    uart_fifo_ram #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc_s),
        .waddr (wridx_r[DEPTH_LOG2-1:0]),
        .wdata (wrdata),
        .re    (ram_re_s),
        .raddr (rdidx_r[DEPTH_LOG2-1:0]),
        .rdata (ram_q_s)
    );

endmodule

// File: tb/tb_uart_fifo_gen.sv
// Scoreboard bench for uart_fifo_gen at DEPTH_LOG2=4, AF_LEVEL=12.
module tb_uart_fifo_gen;

    localparam int W     = 8;
    localparam int DL2   = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [W-1:0] wrdata;
    logic         wr_en;
    logic [W-1:0] rddata;
    logic         rd_en;
    logic         empty;
    logic         full;
    logic [DL2:0] level;
    logic         almost_full;
    logic         overflow;
    logic         ovf_clr;

    logic [W-1:0] exp_q[$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           m_lvl = 0;
    bit           m_ovf = 1'b0;

    always #5 clk = ~clk;

    uart_fifo_gen #(
        .WIDTH      (W),
        .DEPTH_LOG2 (DL2),
        .AF_LEVEL   (AF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wrdata      (wrdata),
        .wr_en       (wr_en),
        .rddata      (rddata),
        .rd_en       (rd_en),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst === 1'b0 && flush === 1'b0 && rd_en === 1'b1 && empty === 1'b0) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_data: got %0h expected no data (scoreboard empty)", rddata);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (rddata !== e) begin
                    n_fail++;
                    $display("FAIL rd_data: got %0h expected %0h at %0t", rddata, e, $time);
                end
            end
        end
    end

    task automatic check_flags(input string tag);
        chk({tag, ".level"}, 32'(level), 32'(m_lvl));
        chk({tag, ".full"}, 32'(full), 32'(m_lvl == DEPTH));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(m_lvl >= AF));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        if (m_lvl == 0) begin
            chk({tag, ".empty"}, 32'(empty), 32'd1);
        end
`ifndef UART_FIFO_FWFT_EN
        else begin
            chk({tag, ".empty"}, 32'(empty), 32'd0);
        end
`endif
    endtask

    task automatic step(input string tag, input bit w, input bit r, input logic [W-1:0] d,
                        input bit clr, input bit fl);
        bit acc_w;
        bit acc_r;
        wr_en   = w;
        rd_en   = r;
        wrdata  = d;
        ovf_clr = clr;
        flush   = fl;
        if (fl) begin
            m_lvl = 0;
            m_ovf = 1'b0;
            exp_q.delete();
        end else begin
            acc_r = r && (m_lvl > 0);
            acc_w = w && (m_lvl < DEPTH);
            if (w && m_lvl == DEPTH) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (acc_w) exp_q.push_back(d);
            m_lvl = m_lvl + int'(acc_w) - int'(acc_r);
        end
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
        flush   = 1'b0;
        check_flags(tag);
    endtask

    task automatic wr(input string tag, input logic [W-1:0] d);
        step(tag, 1'b1, 1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Each pop is followed by an idle cycle so the next head word settles on rddata.
    task automatic rd(input string tag);
        step(tag, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; wrdata = 8'h00;
        #12;
        chk("reset.empty", 32'(empty), 32'd1);
        chk("reset.full", 32'(full), 32'd0);
        chk("reset.level", 32'(level), 32'd0);
        chk("reset.almost_full", 32'(almost_full), 32'd0);
        chk("reset.overflow", 32'(overflow), 32'd0);
        chk("reset.rddata", 32'(rddata), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Basic ordering
        wr("t1.wr", 8'h11); wr("t1.wr", 8'h22); wr("t1.wr", 8'h33);
        idle(2);
        for (int i = 0; i < 3; i++) rd("t1.rd");

        // Fill to full, overflow, overflow+clear collision, drain, clear
        for (int i = 0; i < DEPTH; i++) wr("t2.fill", 8'(8'h40 + i));
        wr("t2.ovf", 8'hEE);
        step("t2.ovf_clr_collide", 1'b1, 1'b0, 8'hEF, 1'b1, 1'b0);
        idle(2);
        for (int i = 0; i < DEPTH; i++) rd("t2.drain");
        step("t2.clr", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous write/read at level 5, full, empty
        for (int i = 0; i < 5; i++) wr("t3.wr5", 8'(8'h60 + i));
        idle(2);
        step("t3.both5", 1'b1, 1'b1, 8'h65, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 5; i++) rd("t3.drain5");
        for (int i = 0; i < DEPTH; i++) wr("t3.fill", 8'(8'h80 + i));
        idle(2);
        step("t3.both_full", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < DEPTH - 1; i++) rd("t3.drain");
        step("t3.clr", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step("t3.both_empty", 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        idle(2);
        rd("t3.rd1");

        // Pointer wrap: 40 words through, three times
        for (int rep = 0; rep < 3; rep++) begin
            for (int c = 0; c < 3; c++) begin
                int n;
                n = (c == 2) ? 8 : DEPTH;
                for (int i = 0; i < n; i++) wr("t4.wr", 8'((rep * 64) + (c * 16) + i + 3));
                idle(2);
                for (int i = 0; i < n; i++) rd("t4.rd");
            end
        end

        // Flush with a concurrent write at level 7
        for (int i = 0; i < 7; i++) wr("t5.wr", 8'(8'hC0 + i));
        step("t5.flush", 1'b1, 1'b0, 8'hCC, 1'b0, 1'b1);
        chk("t5.flush.level", 32'(level), 32'd0);
        chk("t5.flush.empty", 32'(empty), 32'd1);

        // Asynchronous reset in the middle of a write burst
        wr("t6.wr", 8'h01); wr("t6.wr", 8'h02);
        wr_en = 1'b1; wrdata = 8'h03;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        wr_en = 1'b0;
        m_lvl = 0; m_ovf = 1'b0; exp_q.delete();
        chk("t6.rst.empty", 32'(empty), 32'd1);
        chk("t6.rst.full", 32'(full), 32'd0);
        chk("t6.rst.level", 32'(level), 32'd0);
        chk("t6.rst.almost_full", 32'(almost_full), 32'd0);
        chk("t6.rst.overflow", 32'(overflow), 32'd0);
        chk("t6.rst.rddata", 32'(rddata), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Latency of a single word into an empty FIFO
        wr("t7.wr", 8'hA5);
`ifdef UART_FIFO_FWFT_EN
        chk("t7.fwft.empty_e1", 32'(empty), 32'd1);
        @(posedge clk); #1;
        chk("t7.fwft.empty_e2", 32'(empty), 32'd0);
        chk("t7.fwft.rddata", 32'(rddata), 32'h0A5);
`else
        @(posedge clk); #1;
        chk("t7.std.rddata", 32'(rddata), 32'h0A5);
`endif
        idle(1);
        rd("t7.rd");

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d words left expected 0", exp_q.size());
        end
        n_chk++;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
